mmio_uart_tx: RTL and testbench



---
 rtl/mmio_uart_tx.sv | 232 +++++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : mmio_uart_tx
// Description : Memory-mapped UART transmitter with a TX FIFO, a programmable
//               baud divider and a sticky overflow flag. Define
//               UART_TX_PARITY_EN for 8E1 framing; the default build is 8N1.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_uart_tx #(
    parameter logic [15:0] DEFAULT_DIV = 16'd868,
    parameter int          DEPTH       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic [7:0]  addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  ReadControl,
    input  logic [2:0]  WriteControl,
    output logic [31:0] rdata,
    output logic        tx
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = (c_ptr_w + 1 < 3) ? 3 : c_ptr_w + 1;
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd4
    } state_t;
`endif

    state_t               r_state;
    logic [7:0]           r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_cnt_w-1:0]   r_count;
    logic                 r_ovf;
    logic [15:0]          r_baud;
    logic [15:0]          r_div;
    logic [15:0]          r_clk_cnt;
    logic [2:0]           r_bit_cnt;
    logic [7:0]           r_data;
    logic                 r_tx;

    state_t               w_state_nxt;
    logic [15:0]          w_clk_cnt_nxt;
    logic [2:0]           w_bit_cnt_nxt;
    logic [2:0]           w_bit_inc;
    logic                 w_tx_nxt;
    logic                 w_pop;
    logic                 w_wr;
    logic                 w_rd;
    logic                 w_wr_txdata;
    logic                 w_wr_status;
    logic                 w_wr_baud;
    logic                 w_push;
    logic                 w_ovf_set;
    logic                 w_ovf_clr;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_busy;
    logic                 w_bit_end;
    logic [31:0]          w_status;
    logic                 w_unused_bits;

    assign w_wr        = sel && (WriteControl != 3'd0);
    assign w_rd        = sel && (ReadControl != 3'd0);
    assign w_wr_txdata = w_wr && (addr[3:2] == 2'd0);
    assign w_wr_status = w_wr && (addr[3:2] == 2'd1);
    assign w_wr_baud   = w_wr && (addr[3:2] == 2'd2);

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_depth);
    // Full is judged before any same-cycle pop, so a store into a full FIFO always drops.
    assign w_push    = w_wr_txdata && !w_full;
    assign w_ovf_set = w_wr_txdata && w_full;
    assign w_ovf_clr = w_wr_status && wdata[3];
    assign w_busy    = (r_state != IDLE) || !w_empty;
    assign w_bit_end = (r_clk_cnt == r_div - 16'd1);
    assign w_bit_inc = r_bit_cnt + 3'd1;

    assign w_status = {25'd0, r_count[2:0], r_ovf, w_empty, w_full, w_busy};
    assign w_unused_bits = ^{addr[7:4], addr[1:0], wdata[31:16]};

    always_comb begin
        rdata = 32'h0;
        if (w_rd) begin
            case (addr[3:2])
                2'd1:    rdata = w_status;
                2'd2:    rdata = {16'h0, r_baud};
                default: rdata = 32'h0;
            endcase
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clk_cnt_nxt = r_clk_cnt + 16'd1;
        w_bit_cnt_nxt = r_bit_cnt;
        w_tx_nxt      = r_tx;
        w_pop         = 1'b0;
        case (r_state)
            IDLE: begin
                w_clk_cnt_nxt = 16'd0;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = START;
                    w_tx_nxt    = 1'b0;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_clk_cnt_nxt = 16'd0;
                    w_bit_cnt_nxt = 3'd0;
                    w_state_nxt   = DATA;
                    w_tx_nxt      = r_data[0];
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_clk_cnt_nxt = 16'd0;
                    if (r_bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = PARITY;
                        w_tx_nxt    = ^r_data;
`else
                        w_state_nxt = STOP;
                        w_tx_nxt    = 1'b1;
`endif
                    end else begin
                        w_bit_cnt_nxt = w_bit_inc;
                        w_tx_nxt      = r_data[w_bit_inc];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (w_bit_end) begin
                    w_clk_cnt_nxt = 16'd0;
                    w_state_nxt   = STOP;
                    w_tx_nxt      = 1'b1;
                end
            end
`endif
            STOP: begin
                if (w_bit_end) begin
                    w_clk_cnt_nxt = 16'd0;
                    // Chain straight into the next start bit when more data is waiting.
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = START;
                        w_tx_nxt    = 1'b0;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt   = IDLE;
                w_clk_cnt_nxt = 16'd0;
                w_tx_nxt      = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_tx      <= 1'b1;
            r_clk_cnt <= 16'd0;
            r_bit_cnt <= 3'd0;
            r_data    <= 8'd0;
            r_div     <= DEFAULT_DIV;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_ovf     <= 1'b0;
            r_baud    <= DEFAULT_DIV;
        end else begin
            r_state   <= w_state_nxt;
            r_tx      <= w_tx_nxt;
            r_clk_cnt <= w_clk_cnt_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            if (w_pop) begin
                r_data   <= r_mem[r_rd_ptr];
                r_div    <= r_baud;
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end
            if (w_wr_baud) begin
                r_baud <= (wdata[15:0] == 16'd0) ? 16'd1 : wdata[15:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wdata[7:0];
        end
    end

    assign tx = r_tx;

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_uart_tx
// Description : Randomised scoreboard bench for mmio_uart_tx; frames on tx are
//               decoded and compared with a queue of expected bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_uart_tx;

    localparam logic [15:0] c_DEF   = 16'd868;
    localparam int          c_DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int          c_FRAME = 11;
`else
    localparam int          c_FRAME = 10;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic [7:0]  addr = 8'h0;
    logic [31:0] wdata = 32'h0;
    logic [2:0]  ReadControl = 3'd0;
    logic [2:0]  WriteControl = 3'd0;
    logic [31:0] rdata;
    logic        tx;

    always #5 clk = ~clk;

    mmio_uart_tx #(
        .DEFAULT_DIV (c_DEF),
        .DEPTH       (c_DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sel          (sel),
        .addr         (addr),
        .wdata        (wdata),
        .ReadControl  (ReadControl),
        .WriteControl (WriteControl),
        .rdata        (rdata),
        .tx           (tx)
    );

    typedef struct {
        logic [7:0] b;
        int         div;
    } frame_t;

    frame_t     exp_q[$];
    logic [7:0] m_fifo[$];
    logic       m_ovf = 1'b0;
    int         m_div = int'(c_DEF);
    int         cyc = 0;
    int         m_free_at = 0;
    int         checks = 0;
    int         errors = 0;
    bit         mon_busy = 1'b0;

    // Reference model: a byte queue plus the edge at which the line next becomes free.
    initial begin : model
        bit     wr, pop, full_pre;
        frame_t f;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_fifo.delete();
                exp_q.delete();
                m_ovf     = 1'b0;
                m_div     = int'(c_DEF);
                m_free_at = 0;
            end else begin
                cyc++;
                wr       = sel && (WriteControl != 3'd0);
                full_pre = (m_fifo.size() == c_DEPTH);
                pop      = (cyc >= m_free_at) && (m_fifo.size() > 0);
                if (pop) begin
                    f.b       = m_fifo.pop_front();
                    f.div     = m_div;
                    exp_q.push_back(f);
                    m_free_at = cyc + c_FRAME * m_div;
                end
                if (wr) begin
                    case (addr[3:2])
                        2'd0: if (full_pre) m_ovf = 1'b1; else m_fifo.push_back(wdata[7:0]);
                        2'd1: if (wdata[3]) m_ovf = 1'b0;
                        2'd2: m_div = (wdata[15:0] == 16'd0) ? 1 : int'(wdata[15:0]);
                        default: ;
                    endcase
                end
            end
        end
    end

    function automatic logic [31:0] m_status();
        int         n;
        logic [2:0] c3;
        n  = m_fifo.size();
        c3 = n[2:0];
        return {25'd0, c3, m_ovf, n == 0, n == c_DEPTH, (n != 0) || (cyc < m_free_at)};
    endfunction

    // Monitor: decodes every frame on tx and checks each bit for its full period.
    initial begin : monitor
        frame_t      f;
        logic [10:0] bits;
        bit          ok, aborted;
        int          bad_bit;
        logic        got;
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: tx=0 with no byte expected (cycle %0d)", cyc);
                    while (tx === 1'b0 && !rst) @(negedge clk);
                end else begin
                    mon_busy = 1'b1;
                    f        = exp_q.pop_front();
                    bits     = '1;
                    bits[0]  = 1'b0;
                    bits[8:1] = f.b;
`ifdef UART_TX_PARITY_EN
                    bits[9]  = ^f.b;
`endif
                    ok = 1'b1; aborted = 1'b0; bad_bit = -1; got = 1'b0;
                    for (int b = 0; b < c_FRAME && !aborted; b++) begin
                        for (int c = 0; c < f.div && !aborted; c++) begin
                            if (b != 0 || c != 0) @(negedge clk);
                            if (rst) aborted = 1'b1;
                            else if (tx !== bits[b] && ok) begin
                                ok = 1'b0; bad_bit = b; got = tx;
                            end
                        end
                    end
                    if (!aborted) begin
                        checks++;
                        if (!ok) begin
                            errors++;
                            $display("FAIL frame byte=%h div=%0d: bit %0d got %b expected %b",
                                     f.b, f.div, bad_bit, got, bits[bad_bit]);
                        end
                    end
                    mon_busy = 1'b0;
                end
            end
        end
    end

    task automatic bus_idle();
        sel = 1'b0; addr = 8'h0; wdata = 32'h0; ReadControl = 3'd0; WriteControl = 3'd0;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        sel = 1'b1; addr = a; wdata = d; ReadControl = 3'd0; WriteControl = 3'b010;
        @(negedge clk);
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_read(input logic s, input logic [2:0] rc, input logic [7:0] a,
                              input logic [31:0] exp, input string name);
        sel = s; addr = a; ReadControl = rc; WriteControl = 3'd0; wdata = 32'h0;
        #1;
        check_val(name, rdata, exp);
        bus_idle();
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        bus_idle();
        while (!(m_fifo.size() == 0 && cyc >= m_free_at && exp_q.size() == 0 && !mon_busy)
               && n < 20000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 20000) begin
            errors++;
            $display("FAIL drain_timeout: line still busy after %0d cycles", n);
        end
    endtask

    initial begin : stim
        int op;
        bus_idle();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        check_val("reset_tx", {31'd0, tx}, 32'd1);
        check_read(1'b1, 3'd2, 8'h04, 32'h4, "reset_status");
        check_read(1'b1, 3'd2, 8'h08, {16'h0, c_DEF}, "reset_bauddiv");

        // Divider of zero behaves as one clock per bit.
        bus_write(8'h08, 32'h0);
        check_read(1'b1, 3'd2, 8'h08, 32'h1, "baud_zero_as_one");
        bus_write(8'h00, 32'h3C);
        wait_drain();
        bus_write(8'h08, 32'h1234_ABCD);
        check_read(1'b1, 3'd2, 8'h08, 32'h0000_ABCD, "baud_low16");

        // Single byte: tx falls exactly one edge after the store.
        bus_write(8'h08, 32'd4);
        bus_write(8'h00, 32'hA5);
        bus_idle();
        check_val("start_not_early", {31'd0, tx}, 32'd1);
        @(negedge clk);
        check_val("start_edge_k1", {31'd0, tx}, 32'd0);
        wait_drain();

        // Six back-to-back stores into a depth-4 FIFO: one pops, four queue, one drops.
        bus_write(8'h08, 32'd2);
        for (int i = 0; i < 6; i++) bus_write(8'h00, {24'd0, 8'($urandom)});
        bus_idle();
        check_read(1'b1, 3'd2, 8'h04, 32'h4B, "overflow_full_const");
        check_read(1'b1, 3'd2, 8'h04, m_status(), "overflow_full_model");
        bus_write(8'h04, 32'h8);
        bus_idle();
        check_read(1'b1, 3'd2, 8'h04, m_status(), "overflow_cleared");
        bus_write(8'h0C, 32'hFFFF_FFFF);
        bus_idle();
        check_read(1'b1, 3'd2, 8'h04, m_status(), "reserved_write_status");
        check_read(1'b1, 3'd2, 8'h08, 32'd2, "reserved_write_baud");
        check_read(1'b0, 3'd2, 8'h04, 32'h0, "read_sel0");
        check_read(1'b1, 3'd0, 8'h04, 32'h0, "read_rc0");
        check_read(1'b1, 3'd2, 8'h00, 32'h0, "read_txdata");
        check_read(1'b1, 3'd2, 8'h0C, 32'h0, "read_reserved");
        wait_drain();

        // Randomised traffic against the model.
        for (int i = 0; i < 80; i++) begin
            op = int'($urandom_range(0, 99));
            if (op < 55) begin
                bus_write(8'h00, $urandom);
            end else if (op < 65) begin
                bus_write(8'h08, {16'($urandom), 16'($urandom_range(0, 3))});
            end else if (op < 72) begin
                bus_write(8'h04, $urandom);
            end else if (op < 85) begin
                check_read(1'b1, 3'($urandom_range(1, 7)), 8'h04, m_status(), "rand_status");
                check_read(1'b1, 3'd2, 8'h08, 32'(m_div), "rand_baud");
            end else begin
                bus_idle();
                repeat ($urandom_range(1, 40)) @(negedge clk);
            end
        end
        bus_idle();
        @(negedge clk);
        check_read(1'b1, 3'd2, 8'h04, m_status(), "rand_final_status");
        wait_drain();

        // Reset in the middle of the data bits with two bytes still queued.
        bus_write(8'h08, 32'd3);
        bus_write(8'h00, 32'h00);
        bus_write(8'h00, 32'h11);
        bus_write(8'h00, 32'h22);
        bus_idle();
        repeat (6) @(negedge clk);
        check_val("pre_reset_data_bit", {31'd0, tx}, 32'd0);
        #2 rst = 1'b1;
        #1 check_val("async_reset_tx", {31'd0, tx}, 32'd1);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_read(1'b1, 3'd2, 8'h04, 32'h4, "post_reset_status");
        check_read(1'b1, 3'd2, 8'h08, {16'h0, c_DEF}, "post_reset_baud");
        repeat (60) @(negedge clk);
        check_val("no_resume_tx", {31'd0, tx}, 32'd1);
        check_val("no_pending_frames", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
